// File: rtl/bilinear_interpolator.sv
// bilinear_interpolator: 4-tap Q0.10 weighted pixel blend, frame-sequenced,
// fixed 3-cycle latency from an accepted group to out_valid.
module bilinear_interpolator #(
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pix_valid,
  input  logic [7:0] pix_tl,
  input  logic [7:0] pix_tr,
  input  logic [7:0] pix_bl,
  input  logic [7:0] pix_br,
  input  logic [9:0] coeff_tl,
  input  logic [9:0] coeff_tr,
  input  logic [9:0] coeff_bl,
  input  logic [9:0] coeff_br,
  output logic       out_valid,
  output logic [7:0] out_pixel,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIMING = 2'd1,
    RUNNING = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic        v1, v2, v3;
  logic [17:0] p_tl, p_tr, p_bl, p_br;
  logic [18:0] sum_top, sum_bot;
  logic [9:0]  q3;

  logic       active;
  logic       abort;
  logic       take;
  logic       last;
  logic       pipe_empty;
  logic [7:0] sat_pixel;

  assign active     = (state == PRIMING) || (state == RUNNING);
  assign abort      = (state != IDLE) && !start;
  assign take       = active && start && pix_valid;
  assign last       = (cnt + CNT_W'(1)) == CNT_W'(FRAME_PIXELS);
  assign pipe_empty = !(v1 || v2 || v3);
  assign busy       = (state != IDLE);

  // q3 is total>>10; anything above 255 clamps
  assign sat_pixel  = (|q3[9:8]) ? 8'hff : q3[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt <= '0;
            if (start) state <= PRIMING;
          end
          PRIMING, RUNNING: begin
            if (pix_valid) begin
              cnt   <= cnt + CNT_W'(1);
              state <= last ? DRAIN : RUNNING;
            end
          end
          DRAIN: begin
            if (pipe_empty) begin
              state      <= IDLE;
              cnt        <= '0;
              frame_done <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // valid bits ride alongside the data; an abort wipes every stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      p_tl      <= '0;
      p_tr      <= '0;
      p_bl      <= '0;
      p_br      <= '0;
      sum_top   <= '0;
      sum_bot   <= '0;
      q3        <= '0;
      out_pixel <= '0;
    end else begin
      v1        <= take;
      v2        <= v1 && !abort;
      v3        <= v2 && !abort;
      out_valid <= v3 && !abort;
      if (take) begin
        p_tl <= 18'(pix_tl) * 18'(coeff_tl);
        p_tr <= 18'(pix_tr) * 18'(coeff_tr);
        p_bl <= 18'(pix_bl) * 18'(coeff_bl);
        p_br <= 18'(pix_br) * 18'(coeff_br);
      end
      if (v1) begin
        sum_top <= {1'b0, p_tl} + {1'b0, p_tr};
        sum_bot <= {1'b0, p_bl} + {1'b0, p_br};
      end
      if (v2) begin
        q3 <= 10'(({1'b0, sum_top} + {1'b0, sum_bot} + 20'd512) >> 10);
      end
      if (v3) out_pixel <= sat_pixel;
    end
  end

endmodule

// File: doc/bilinear_interpolator.md
BILINEAR_INTERPOLATOR -- requirements
Module: bilinear_interpolator

Interface
REQ-001 Parameter FRAME_PIXELS, default 307200; output pixels per frame (640x480).
REQ-002 Parameter CNT_W, default 20; width of the accepted-pixel counter, SHALL satisfy 2^CNT_W > FRAME_PIXELS.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level; high = frame active, low = abort/idle.
REQ-006 pix_valid  input  1  pixel group and coefficients valid this cycle.
REQ-007 pix_tl, pix_tr, pix_bl, pix_br  input  8 each  neighbour pixels from BRAM reader.
REQ-008 coeff_tl, coeff_tr, coeff_bl, coeff_br  input  10 each  Q0.10 weights from coefficient FIFO output, aligned with pix_valid.
REQ-009 out_valid  output  1  out_pixel valid.
REQ-010 out_pixel  output  8  interpolated pixel.
REQ-011 busy  output  1  high in PRIMING, RUNNING, DRAIN.
REQ-012 frame_done  output  1  one-cycle pulse after last pixel of frame leaves.

Function
REQ-013 States: IDLE, PRIMING, RUNNING, DRAIN; encoded in 2 bits.
REQ-014 IDLE -> PRIMING when start=1; pix_valid ignored in IDLE.
REQ-015 PRIMING -> RUNNING on first cycle with pix_valid=1; that group is accepted (counted and entered into pipeline) in the same cycle.
REQ-016 RUNNING: every pix_valid=1 cycle accepted; counter increments by 1 per accepted group; pix_valid=0 inserts a bubble, no stall upstream.
REQ-017 When the accepted group brings the count to FRAME_PIXELS, next state DRAIN; further pix_valid ignored until IDLE.
REQ-018 DRAIN lasts until pipeline holds no valid data (3 cycles after last accept), then frame_done pulses 1 cycle and state -> IDLE on same edge.
REQ-019 start=0 in PRIMING, RUNNING or DRAIN: next state IDLE, counter cleared, all pipeline valid bits cleared, no frame_done; highest priority over REQ-015..018.
REQ-020 start held high after return to IDLE: PRIMING re-entered next cycle (back-to-back frames).
REQ-021 Pipeline, 3 registered stages, fixed latency 3: accept at edge N -> out_valid at edge N+3.
REQ-022 Stage 1: four unsigned products pix_x*coeff_x, 18 bits each.
REQ-023 Stage 2: sum_top = tl+tr, sum_bot = bl+br, 19 bits each.
REQ-024 Stage 3: total = sum_top + sum_bot + 512 (20 bits, no overflow possible); out_pixel = total>>10 saturated to 255.
REQ-025 Coefficient sum not checked; sums >1024 saturate per REQ-024.
REQ-026 Valid bit travels with data; data registers need not be cleared on bubbles, out_pixel only meaningful when out_valid=1.
REQ-027 out_valid never high in IDLE except for no case: aborts flush per REQ-019.

Reset
REQ-028 rst=0 asynchronously forces IDLE, counter=0, pipeline valid bits=0, out_valid=0, out_pixel=0, busy=0, frame_done=0.
REQ-029 Reset mid-frame identical to REQ-028; first post-reset frame requires start rising through IDLE->PRIMING.

Verification
REQ-030 start=1, pixels all 100, coeffs 256 each, pix_valid every cycle -> out_valid 3 cycles after first accept, out_pixel=100.
REQ-031 pix_tl=255, coeff_tl=1023, others 0 -> out_pixel=255; pix_tl=1, coeff_tl=512 -> (512+512)>>10 = 1.
REQ-032 All pixels 255, all coeffs 1023 -> out_pixel saturates to 255, no wrap.
REQ-033 FRAME_PIXELS=8, pix_valid toggling 1/0 -> exactly 8 out_valid pulses, busy high throughout, frame_done one cycle after 8th out_valid's DRAIN completes, then IDLE.
REQ-034 Drop start after 3 accepts -> next cycle IDLE, out_valid=0 thereafter, no frame_done; reassert start -> count restarts at 0.
REQ-035 Assert rst low mid-RUNNING between clock edges -> outputs zero immediately, before next clk edge.
